// File: rtl/idma_inoc_cfg_mc.sv
// Multi-channel APB register file and per-channel descriptor FIFOs for the iDMA inoc read path.
// Doorbells push {ADDR,NUM}; engines pop by valid/ready and report completion into sticky interrupts.
module idma_inoc_cfg_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [APB_ADDR_WIDTH-1:0]   io_apb_PADDR,
  input  logic                        io_apb_PSEL,
  input  logic                        io_apb_PENABLE,
  input  logic                        io_apb_PWRITE,
  input  logic [3:0]                  io_apb_PSTRB,
  input  logic [31:0]                 io_apb_PWDATA,
  output logic [31:0]                 io_apb_PRDATA,
  output logic                        io_apb_PREADY,
  output logic                        io_apb_PSLVERR,
  output logic [NUM_CH-1:0]           io_rd_req_valid,
  input  logic [NUM_CH-1:0]           io_rd_req_ready,
  output logic [NUM_CH*32-1:0]        io_rd_addr,
  output logic [NUM_CH*32-1:0]        io_rd_num,
  output logic [NUM_CH*4-1:0]         io_rd_cfg_outstd,
  output logic [NUM_CH-1:0]           io_rd_cfg_outstd_en,
  output logic [NUM_CH-1:0]           io_rd_cfg_cross4k_en,
  output logic [NUM_CH*7-1:0]         io_rd_cfg_dfifo_thd,
  input  logic [NUM_CH-1:0]           io_rd_done,
  output logic                        io_intr
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  function automatic logic [31:0] bwr(input logic [31:0] old, input logic [31:0] wd,
                                      input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  logic [NUM_CH-1:0][31:0]                  addr_q, addr_d, num_q, num_d;
  logic [NUM_CH-1:0][14:0]                  cfg_q, cfg_d;
  logic [NUM_CH-1:0][QUEUE_DEPTH-1:0][63:0] mem_q, mem_d;
  logic [NUM_CH-1:0][PtrW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NUM_CH-1:0][CntW-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]             outstd_q, outstd_d;
  logic [NUM_CH-1:0] done_stat_q, done_stat_d, err_stat_q, err_stat_d;
  logic [NUM_CH-1:0] done_en_q, done_en_d, err_en_q, err_en_d;
  logic              intr_q, intr_d;

  logic       access, any_strb, hi_zero, ch_ok, glb_stat, glb_en;
  logic       off_addr, off_num, off_db, off_st, off_cfg, hit;
  logic [2:0] ch_idx;
  logic [4:0] off;
  logic [NUM_CH-1:0] full, empty, wr_c, push, pop, stall;

  assign access   = io_apb_PSEL & io_apb_PENABLE;
  assign any_strb = |io_apb_PSTRB;
  assign ch_idx   = io_apb_PADDR[7:5];
  assign off      = io_apb_PADDR[4:0];
  assign hi_zero  = io_apb_PADDR[APB_ADDR_WIDTH-1:8] == '0;
  assign ch_ok    = hi_zero && (32'(ch_idx) < NUM_CH);
  assign off_addr = off == 5'h00;
  assign off_num  = off == 5'h04;
  assign off_db   = off == 5'h08;
  assign off_st   = off == 5'h0C;
  assign off_cfg  = off == 5'h10;
  assign glb_stat = io_apb_PADDR == APB_ADDR_WIDTH'(32'h100);
  assign glb_en   = io_apb_PADDR == APB_ADDR_WIDTH'(32'h104);
  assign hit      = (ch_ok & (off_addr | off_num | off_db | off_st | off_cfg)) | glb_stat | glb_en;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = cnt_q[c] == CntW'(QUEUE_DEPTH);
      empty[c] = cnt_q[c] == '0;
      wr_c[c]  = access & io_apb_PWRITE & ch_ok & (ch_idx == 3'(c));
      // A doorbell on a full queue stalls; it completes only once a pop has landed.
      stall[c] = wr_c[c] & off_db & any_strb & full[c];
      push[c]  = wr_c[c] & off_db & any_strb & ~full[c];
      pop[c]   = ~empty[c] & io_rd_req_ready[c];
    end
  end

  always_comb begin
    addr_d      = addr_q;
    num_d       = num_q;
    cfg_d       = cfg_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    outstd_d    = outstd_q;
    done_en_d   = done_en_q;
    err_en_d    = err_en_q;
    done_stat_d = done_stat_q;
    err_stat_d  = err_stat_q;
    if (access && io_apb_PWRITE && glb_stat && any_strb) begin
      done_stat_d = done_stat_q & ~io_apb_PWDATA[NUM_CH-1:0];
      err_stat_d  = err_stat_q & ~io_apb_PWDATA[8 +: NUM_CH];
    end
    if (access && io_apb_PWRITE && glb_en) begin
      if (io_apb_PSTRB[0]) done_en_d = io_apb_PWDATA[NUM_CH-1:0];
      if (io_apb_PSTRB[1]) err_en_d  = io_apb_PWDATA[8 +: NUM_CH];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_c[c] && off_addr) addr_d[c] = bwr(addr_q[c], io_apb_PWDATA, io_apb_PSTRB);
      if (wr_c[c] && off_num)  num_d[c]  = bwr(num_q[c], io_apb_PWDATA, io_apb_PSTRB);
      if (wr_c[c] && off_cfg)
        cfg_d[c] = 15'(bwr({17'b0, cfg_q[c]}, io_apb_PWDATA, io_apb_PSTRB) & 32'h7F3F);
      if (push[c]) begin
        mem_d[c][wptr_q[c]] = {addr_q[c], num_q[c]};
        wptr_d[c]           = wptr_q[c] + PtrW'(1);
      end
      if (pop[c]) rptr_d[c] = rptr_q[c] + PtrW'(1);
      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CntW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CntW'(1);
        default: ;
      endcase
      case ({pop[c], io_rd_done[c]})
        2'b10: if (outstd_q[c] != '1) outstd_d[c] = outstd_q[c] + CNT_W'(1);
        2'b01: begin
          if (outstd_q[c] == '0) err_stat_d[c] = 1'b1;
          else                   outstd_d[c]   = outstd_q[c] - CNT_W'(1);
        end
        default: ;
      endcase
      if (io_rd_done[c]) done_stat_d[c] = 1'b1;
    end
    intr_d = |((done_stat_q & done_en_q) | (err_stat_q & err_en_q));
  end

  always_comb begin
    io_apb_PRDATA  = '0;
    io_apb_PREADY  = ~|stall;
    io_apb_PSLVERR = access & ~hit;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_ok && ch_idx == 3'(c)) begin
        if (off_addr) io_apb_PRDATA = addr_q[c];
        if (off_num)  io_apb_PRDATA = num_q[c];
        if (off_cfg)  io_apb_PRDATA = {17'b0, cfg_q[c]};
        if (off_st) begin
          io_apb_PRDATA[4:0]          = 5'(cnt_q[c]);
          io_apb_PRDATA[8]            = full[c];
          io_apb_PRDATA[9]            = empty[c];
          io_apb_PRDATA[16 +: CNT_W]  = outstd_q[c];
        end
      end
      if (glb_stat) begin
        io_apb_PRDATA[c]     = done_stat_q[c];
        io_apb_PRDATA[8 + c] = err_stat_q[c];
      end
      if (glb_en) begin
        io_apb_PRDATA[c]     = done_en_q[c];
        io_apb_PRDATA[8 + c] = err_en_q[c];
      end
      io_rd_req_valid[c]          = ~empty[c];
      io_rd_addr[32*c +: 32]      = mem_q[c][rptr_q[c]][63:32];
      io_rd_num[32*c +: 32]       = mem_q[c][rptr_q[c]][31:0];
      io_rd_cfg_outstd[4*c +: 4]  = cfg_q[c][3:0];
      io_rd_cfg_outstd_en[c]      = cfg_q[c][4];
      io_rd_cfg_cross4k_en[c]     = cfg_q[c][5];
      io_rd_cfg_dfifo_thd[7*c +: 7] = cfg_q[c][14:8];
    end
  end

  assign io_intr = intr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q      <= '0;
      num_q       <= '0;
      cfg_q       <= '0;
      mem_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      outstd_q    <= '0;
      done_stat_q <= '0;
      err_stat_q  <= '0;
      done_en_q   <= '0;
      err_en_q    <= '0;
      intr_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      num_q       <= num_d;
      cfg_q       <= cfg_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      outstd_q    <= outstd_d;
      done_stat_q <= done_stat_d;
      err_stat_q  <= err_stat_d;
      done_en_q   <= done_en_d;
      err_en_q    <= err_en_d;
      intr_q      <= intr_d;
    end
  end

endmodule

// File: tb/tb_idma_inoc_cfg_mc.sv
// Directed bench for idma_inoc_cfg_mc: doorbell/FIFO flow, back-pressure, interrupts, errors, reset.
module tb_idma_inoc_cfg_mc;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [11:0]  paddr;
  logic         psel, penable, pwrite;
  logic [3:0]   pstrb;
  logic [31:0]  pwdata, prdata;
  logic         pready, pslverr;
  logic [3:0]   valid, ready, done;
  logic [127:0] rd_addr, rd_num;
  logic [15:0]  cfg_outstd;
  logic [3:0]   cfg_outstd_en, cfg_cross4k_en;
  logic [27:0]  cfg_thd;
  logic         intr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        err;
  int          nw;

  always #5 aclk = ~aclk;

  idma_inoc_cfg_mc dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .io_apb_PADDR         (paddr),
    .io_apb_PSEL          (psel),
    .io_apb_PENABLE       (penable),
    .io_apb_PWRITE        (pwrite),
    .io_apb_PSTRB         (pstrb),
    .io_apb_PWDATA        (pwdata),
    .io_apb_PRDATA        (prdata),
    .io_apb_PREADY        (pready),
    .io_apb_PSLVERR       (pslverr),
    .io_rd_req_valid      (valid),
    .io_rd_req_ready      (ready),
    .io_rd_addr           (rd_addr),
    .io_rd_num            (rd_num),
    .io_rd_cfg_outstd     (cfg_outstd),
    .io_rd_cfg_outstd_en  (cfg_outstd_en),
    .io_rd_cfg_cross4k_en (cfg_cross4k_en),
    .io_rd_cfg_dfifo_thd  (cfg_thd),
    .io_rd_done           (done),
    .io_intr              (intr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_setup(input logic wr, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    @(posedge aclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge aclk); #1;
    penable = 1'b1;
  endtask

  task automatic apb_end(output logic [31:0] data, output logic serr, output int waits);
    waits = 0;
    @(negedge aclk);
    while (!pready && waits < 64) begin
      waits++;
      @(negedge aclk);
    end
    if (waits >= 64) chk("apb_timeout", {63'b0, pready}, 64'd1);
    data = prdata;
    serr = pslverr;
    @(posedge aclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] dd;
    logic        ee;
    int          ww;
    apb_setup(1'b1, a, d, s);
    apb_end(dd, ee, ww);
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    int ww;
    apb_setup(1'b0, a, 32'h0, 4'h0);
    apb_end(d, e, ww);
  endtask

  initial begin
    aresetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; ready = '0; done = '0;
    #12;
    chk("rst_pready", {63'b0, pready}, 64'd1);
    chk("rst_intr", {63'b0, intr}, 64'd0);
    chk("rst_valid", {60'b0, valid}, 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    apb_rd(12'h00C, rd, err);
    chk("rst_status0", {32'b0, rd}, 64'h200);

    // 1: single descriptor on ch0
    apb_wr(12'h000, 32'h8000_1000);
    apb_wr(12'h004, 32'h200);
    apb_wr(12'h008, 32'h1);
    chk("t1_valid0", {63'b0, valid[0]}, 64'd1);
    chk("t1_addr0", {32'b0, rd_addr[31:0]}, 64'h8000_1000);
    chk("t1_num0", {32'b0, rd_num[31:0]}, 64'h200);
    apb_rd(12'h00C, rd, err);
    chk("t1_status0", {32'b0, rd}, 64'h1);

    // 2: fill ch1, stall 5th doorbell, release with one pop
    for (int i = 0; i < 4; i++) begin
      apb_wr(12'h020, 32'h1000 + 32'(i) * 32'h100);
      apb_wr(12'h024, 32'h10 + 32'(i));
      apb_wr(12'h028, 32'h1);
    end
    apb_rd(12'h02C, rd, err);
    chk("t2_status_full", {32'b0, rd}, 64'h104);
    apb_wr(12'h020, 32'h1400);
    apb_setup(1'b1, 12'h028, 32'h1, 4'hF);
    @(negedge aclk);
    chk("t2_stall_a", {63'b0, pready}, 64'd0);
    @(negedge aclk);
    chk("t2_stall_b", {63'b0, pready}, 64'd0);
    @(posedge aclk); #1 ready[1] = 1'b1;
    @(negedge aclk);
    chk("t2_stall_popcycle", {63'b0, pready}, 64'd0);
    chk("t2_head_first", {32'b0, rd_addr[63:32]}, 64'h1000);
    @(posedge aclk); #1 ready[1] = 1'b0;
    apb_end(rd, err, nw);
    chk("t2_db5_waits", 64'(nw), 64'd0);
    apb_rd(12'h02C, rd, err);
    chk("t2_status_after", {32'b0, rd}, 64'h10104);
    @(posedge aclk); #1 ready[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      chk("t2_pop_order", {32'b0, rd_addr[63:32]}, 64'h1100 + 64'(j) * 64'h100);
      @(posedge aclk); #1;
    end
    ready[1] = 1'b0;
    chk("t2_drained", {63'b0, valid[1]}, 64'd0);

    // 3: simultaneous push and pop on ch2
    apb_wr(12'h040, 32'h2000);
    apb_wr(12'h048, 32'h1);
    apb_wr(12'h040, 32'h2100);
    apb_wr(12'h048, 32'h1);
    apb_wr(12'h040, 32'h2200);
    apb_setup(1'b1, 12'h048, 32'h1, 4'hF);
    ready[2] = 1'b1;
    chk("t3_head0", {32'b0, rd_addr[95:64]}, 64'h2000);
    apb_end(rd, err, nw);
    ready[2] = 1'b0;
    apb_rd(12'h04C, rd, err);
    chk("t3_status", {32'b0, rd}, 64'h10002);
    @(posedge aclk); #1 ready[2] = 1'b1;
    @(negedge aclk);
    chk("t3_head1", {32'b0, rd_addr[95:64]}, 64'h2100);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t3_head2", {32'b0, rd_addr[95:64]}, 64'h2200);
    @(posedge aclk); #1 ready[2] = 1'b0;
    chk("t3_empty", {63'b0, valid[2]}, 64'd0);

    // 4: completion interrupt on ch0
    apb_wr(12'h104, 32'h1);
    @(posedge aclk); #1 ready[0] = 1'b1;
    @(posedge aclk); #1 ready[0] = 1'b0; done[0] = 1'b1;
    @(posedge aclk); #1 done[0] = 1'b0;
    chk("t4_intr_lag", {63'b0, intr}, 64'd0);
    @(posedge aclk); #1;
    chk("t4_intr_set", {63'b0, intr}, 64'd1);
    apb_rd(12'h100, rd, err);
    chk("t4_stat", {32'b0, rd}, 64'h1);
    apb_wr(12'h100, 32'h1);
    @(posedge aclk); #1;
    chk("t4_intr_clr", {63'b0, intr}, 64'd0);
    apb_setup(1'b1, 12'h100, 32'h1, 4'hF);
    done[0] = 1'b1;
    apb_end(rd, err, nw);
    done[0] = 1'b0;
    apb_rd(12'h100, rd, err);
    chk("t4_set_wins", {32'b0, rd}, 64'h101);
    apb_wr(12'h100, 32'h101);
    apb_rd(12'h100, rd, err);
    chk("t4_cleared", {32'b0, rd}, 64'h0);

    // 5: done with no outstanding on ch3, bad address
    @(posedge aclk); #1 done[3] = 1'b1;
    @(posedge aclk); #1 done[3] = 1'b0;
    apb_rd(12'h100, rd, err);
    chk("t5_err_bit", {32'b0, rd}, 64'h808);
    apb_rd(12'h06C, rd, err);
    chk("t5_status3", {32'b0, rd}, 64'h200);
    chk("t5_intr", {63'b0, intr}, 64'd0);
    apb_rd(12'h0FC, rd, err);
    chk("t5_slverr", {63'b0, err}, 64'd1);
    chk("t5_rdata", {32'b0, rd}, 64'h0);
    apb_rd(12'h008, rd, err);
    chk("t5_db_read", {31'b0, err, rd}, 64'h0);

    // 6: CFG strobes, then reset during a stalled doorbell
    apb_wr(12'h010, 32'hFFFF, 4'h1);
    apb_rd(12'h010, rd, err);
    chk("t6_cfg_strb", {32'b0, rd}, 64'h3F);
    apb_wr(12'h010, 32'hFFFF_FFFF);
    apb_rd(12'h010, rd, err);
    chk("t6_cfg_mask", {32'b0, rd}, 64'h7F3F);
    chk("t6_cfg_out", {30'b0, cfg_thd[6:0], cfg_cross4k_en[0], cfg_outstd_en[0],
                       cfg_outstd[3:0]}, {30'b0, 7'h7F, 1'b1, 1'b1, 4'hF});
    for (int i = 0; i < 4; i++) apb_wr(12'h028, 32'h1);
    apb_setup(1'b1, 12'h028, 32'h1, 4'hF);
    @(negedge aclk);
    chk("t6_stall", {63'b0, pready}, 64'd0);
    #1 aresetn = 1'b0;
    #1;
    chk("t6_rst_pready", {63'b0, pready}, 64'd1);
    chk("t6_rst_valid", {60'b0, valid}, 64'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge aclk); #1 aresetn = 1'b1;
    apb_rd(12'h010, rd, err);
    chk("t6_cfg_reset", {32'b0, rd}, 64'h0);
    chk("t6_cfg_out_reset", {36'b0, cfg_thd}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/idma_inoc_cfg_mc.md
Name: idma_inoc_cfg_mc

Overview:
Multi-channel APB configuration and descriptor-queue block for the iDMA inoc read path. It replaces the single-channel regfile in the successor config wrapper and sits between the axi2apb bridge and NUM_CH DMA read engines. Software writes per-channel address and length, then rings a doorbell to push a descriptor into a per-channel FIFO. Engines pop descriptors by valid/ready and report completion; completions raise maskable, sticky interrupts.

Parameters:
NUM_CH, 4, number of DMA channels (1..8)
QUEUE_DEPTH, 4, descriptors per channel FIFO (power of 2, 2..16)
APB_ADDR_WIDTH, 12, APB address width
CNT_W, 8, width of per-channel outstanding-descriptor counter

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
io_apb_PADDR  in  APB_ADDR_WIDTH  APB address
io_apb_PSEL  in  1  APB select
io_apb_PENABLE  in  1  APB enable
io_apb_PWRITE  in  1  APB write
io_apb_PSTRB  in  4  APB byte strobes
io_apb_PWDATA  in  32  APB write data
io_apb_PRDATA  out  32  APB read data
io_apb_PREADY  out  1  APB ready
io_apb_PSLVERR  out  1  APB error
io_rd_req_valid  out  NUM_CH  descriptor valid, one bit per channel
io_rd_req_ready  in  NUM_CH  engine accepts descriptor
io_rd_addr  out  NUM_CH*32  head descriptor address; channel c at [32c+31:32c]
io_rd_num  out  NUM_CH*32  head descriptor byte count; same packing
io_rd_cfg_outstd  out  NUM_CH*4  per-channel outstanding limit
io_rd_cfg_outstd_en  out  NUM_CH  outstanding-limit enable
io_rd_cfg_cross4k_en  out  NUM_CH  4K-crossing split enable
io_rd_cfg_dfifo_thd  out  NUM_CH*7  data FIFO threshold
io_rd_done  in  NUM_CH  one-cycle descriptor-complete pulse
io_intr  out  1  combined interrupt

Behaviour:
- Clock and reset: one clock aclk; reset aresetn is asynchronous and active-low.
- Reset values: all outputs and registers are 0, FIFOs are empty, io_apb_PREADY=1 and io_intr=0.
- Channel c uses a 0x20-byte window at c*0x20. The window holds:
  - 0x00 ADDR (RW)
  - 0x04 NUM (RW)
  - 0x08 DOORBELL (WO; reads return 0)
  - 0x0C STATUS (RO): [4:0] fifo count, [8] full, [9] empty, [23:16] outstanding counter
  - 0x10 CFG (RW): [3:0] outstd, [4] outstd_en, [5] cross4k_en, [14:8] dfifo_thd
- Global registers:
  - 0x100 INTR_STAT (RW1C): [NUM_CH-1:0] done, [NUM_CH+7:8] error
  - 0x104 INTR_EN (RW), same layout as INTR_STAT
- Any other address, or a channel index >= NUM_CH, completes with PSLVERR=1 in the access phase, has no side effect and reads 0.
- PSTRB applies byte-wise to RW registers. DOORBELL and W1C act on any write with PSTRB!=0.
- Reads and ordinary writes have zero wait states: PREADY=1 in the access phase and PRDATA is combinational from registers.
- DOORBELL write when FIFO not full: PREADY=1 and {ADDR,NUM} is pushed at the access-phase edge.
- DOORBELL write when FIFO full: PREADY=0 (wait states) until an entry pops. The push then occurs on the same edge PREADY=1 is sampled. A pop and a doorbell in the same cycle on a full FIFO are not allowed to complete together; PREADY rises the cycle after the pop.
- FIFO:
  - io_rd_req_valid[c] = !empty. Head data is stable while valid && !ready.
  - Pop occurs on valid&&ready.
  - Simultaneous push and pop when not full: count is unchanged and data order is preserved.
  - Pointers wrap modulo QUEUE_DEPTH.
- Outstanding counter:
  - +1 on pop, -1 on io_rd_done[c]; both in the same cycle leave it unchanged.
  - io_rd_done with counter 0: counter stays 0 and error bit 8+c is set.
  - The counter saturates at 2^CNT_W-1.
- io_rd_done[c] sets INTR_STAT[c].
- W1C clear and a same-cycle set: set wins.
- io_intr is registered: io_intr = |(INTR_STAT & INTR_EN), one cycle after the status update.
- CFG outputs are driven directly from registers.
- Reset mid-transfer: FIFOs, counters and PREADY return to reset values immediately (asynchronous). A pending stalled APB doorbell is dropped.

Test Plan:
1. Ch0: write ADDR=0x8000_1000, NUM=0x200, then DOORBELL -> io_rd_req_valid[0]=1, io_rd_addr[31:0]=0x8000_1000, io_rd_num[31:0]=0x200; STATUS count=1.
2. Ch1: hold ready low and ring 4 doorbells (QUEUE_DEPTH=4) -> STATUS full=1. Ring a 5th doorbell -> PREADY=0. Pulse ready once -> PREADY=1 the next cycle; count stays 4; pops come out in FIFO order.
3. Ch2: simultaneous push and pop with count=2 -> count stays 2; pop 3 descriptors and observe addresses in write order.
4. Ch0: pop one descriptor, then assert io_rd_done[0] with INTR_EN=0x1 -> INTR_STAT=0x1, io_intr=1 one cycle later. Write 0x1 to INTR_STAT -> io_intr=0. Repeat the clear in the same cycle as a new done -> bit stays 1.
5. Ch3: io_rd_done with outstanding=0 -> INTR_STAT bit 11 set, counter stays 0. Read 0x0FC -> PSLVERR=1, PRDATA=0.
6. Assert aresetn low while a doorbell stall is pending -> PREADY=1 and all FIFOs empty immediately; after release, CFG reads 0.
